// File: rtl/ifu_pc_gen.sv
// rtl/ifu_pc_gen.sv - fetch PC generator with in-order response tagging and redirect drain
// Optional feature macro: IFU_ALIGN_CHK_EN (misaligned redirect reporting)

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif

module ifu_pc_gen #(
    parameter logic [`INST_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int                          MAX_OS   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        jump_flag_i,
    input  logic [`INST_ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                        hold_i,
    output logic                        req_valid_o,
    input  logic                        req_ready_i,
    output logic [`INST_ADDR_WIDTH-1:0] req_addr_o,
    input  logic                        rsp_valid_i,
    input  logic [`INST_DATA_WIDTH-1:0] rsp_data_i,
    output logic                        inst_valid_o,
    output logic [`INST_DATA_WIDTH-1:0] inst_o,
    output logic [`INST_ADDR_WIDTH-1:0] inst_addr_o,
    output logic                        misalign_o,
    output logic [`INST_ADDR_WIDTH-1:0] misalign_addr_o
);

    localparam int AW = `INST_ADDR_WIDTH;
    localparam int CW = $clog2(MAX_OS + 1);
    localparam int PW = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;
    localparam logic [CW-1:0] MAX_OS_C  = CW'(MAX_OS);
    localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OS - 1);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] pc_q;
    logic [CW-1:0] os_cnt;
    logic [CW-1:0] drop_cnt;

    // PC FIFO: one entry per outstanding live fetch, head is the PC of the next response
    logic [AW-1:0] pc_fifo [MAX_OS];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          fire;
    logic          rsp_take;
    logic          rsp_deliver;
    logic [CW-1:0] stale;
    logic [CW-1:0] os_cnt_nxt;
    logic [CW-1:0] drop_cnt_nxt;
    logic [AW-1:0] jump_target;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PW'(1);
    endfunction

    assign jump_target = {jump_addr_i[AW-1:2], 2'b00};

    // A request is only offered in RUN; a same-cycle redirect or stall suppresses it,
    // and a response freeing a slot this cycle does not open room early.
    assign req_valid_o = (state == RUN) & ~jump_flag_i & ~hold_i & (os_cnt < MAX_OS_C);
    assign req_addr_o  = pc_q;
    assign fire        = req_valid_o & req_ready_i;

    // Responses with nothing outstanding are stray and ignored entirely
    assign rsp_take    = rsp_valid_i & (os_cnt != '0);
    assign rsp_deliver = rsp_take & (state == RUN) & ~jump_flag_i;

    assign inst_valid_o = rsp_deliver;
    assign inst_o       = rsp_data_i;
    assign inst_addr_o  = pc_fifo[rd_ptr];

    // Fetches still owed by the bus after this cycle that belong to the old path
    assign stale        = os_cnt - CW'(rsp_take);
    assign os_cnt_nxt   = os_cnt + CW'(fire) - CW'(rsp_take);
    assign drop_cnt_nxt = (rsp_take && (drop_cnt != '0)) ? drop_cnt - CW'(1) : drop_cnt;

    // Control FSM: boot for one cycle, run, drain stale responses after a redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (jump_flag_i && (stale != '0)) state <= DRAIN;
                DRAIN:   if (drop_cnt_nxt == '0) state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

    // Drop counter: loaded on a redirect from RUN, counts down each response while draining.
    // A further redirect while draining leaves it alone since the same fetches are still owed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if ((state == RUN) && jump_flag_i) begin
            drop_cnt <= stale;
        end else if (state == DRAIN) begin
            drop_cnt <= drop_cnt_nxt;
        end
    end

    // Fetch PC: redirect wins over sequential advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (jump_flag_i) begin
            pc_q <= jump_target;
        end else if (fire) begin
            pc_q <= pc_q + AW'(4);
        end
    end

    // Outstanding counter covers both live and stale fetches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt <= '0;
        end else begin
            os_cnt <= os_cnt_nxt;
        end
    end

    // FIFO pointers: a redirect flushes every tagged PC; stale responses never pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (jump_flag_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fire)        wr_ptr <= ptr_inc(wr_ptr);
            if (rsp_deliver) rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // FIFO storage: capture the PC of every accepted request
    always_ff @(posedge clk) begin
        if (fire) begin
            pc_fifo[wr_ptr] <= pc_q;
        end
    end

`ifdef IFU_ALIGN_CHK_EN
    logic          misalign_q;
    logic [AW-1:0] misalign_addr_q;

    // Misalign report: one-cycle pulse after the redirect, address held until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q <= jump_flag_i & (jump_addr_i[1:0] != 2'b00);
            if (jump_flag_i && (jump_addr_i[1:0] != 2'b00)) begin
                misalign_addr_q <= jump_addr_i;
            end
        end
    end

    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;
`else
    logic unused_jump_low;

    assign unused_jump_low = ^jump_addr_i[1:0];
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = '0;
`endif

endmodule

// File: tb/tb_ifu_pc_gen.sv
// tb/tb_ifu_pc_gen.sv - randomized and directed bench for ifu_pc_gen against a queue model

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif

module tb_ifu_pc_gen;

    localparam int          MAX_OS   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_i = 1'b0;
    logic        req_valid_o;
    logic        req_ready_i = 1'b0;
    logic [31:0] req_addr_o;
    logic        rsp_valid_i = 1'b0;
    logic [31:0] rsp_data_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    int checks = 0;
    int errors = 0;

    ifu_pc_gen #(.RESET_PC(RESET_PC), .MAX_OS(MAX_OS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .hold_i          (hold_i),
        .req_valid_o     (req_valid_o),
        .req_ready_i     (req_ready_i),
        .req_addr_o      (req_addr_o),
        .rsp_valid_i     (rsp_valid_i),
        .rsp_data_i      (rsp_data_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_addr_o     (inst_addr_o),
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o)
    );

    always #5 clk = ~clk;

    // Reference model: each in-flight fetch is a queue entry; a redirect marks every
    // remaining entry stale, and nothing new is fetched until stale entries have returned.
    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_mis;
    logic [31:0] m_mis_addr;

    function automatic bit m_has_stale();
        foreach (mq[i]) if (mq[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_running();
        return !m_boot && !m_has_stale();
    endfunction

    function automatic bit exp_req_valid();
        return m_running() && !jump_flag_i && !hold_i && (mq.size() < MAX_OS);
    endfunction

    function automatic bit exp_inst_valid();
        return rsp_valid_i && (mq.size() > 0) && m_running() && !jump_flag_i;
    endfunction

    task automatic drive(input bit jf, input logic [31:0] ja, input bit hd,
                         input bit rdy, input bit rv, input logic [31:0] rd);
        @(negedge clk);
        jump_flag_i = jf;
        jump_addr_i = ja;
        hold_i      = hd;
        req_ready_i = rdy;
        rsp_valid_i = rv;
        rsp_data_i  = rd;
        #1;
    endtask

    task automatic advance();
        bit     fire;
        bit     take;
        entry_t e;
        fire = exp_req_valid() && req_ready_i;
        take = rsp_valid_i && (mq.size() > 0);
        if (jump_flag_i && (jump_addr_i[1:0] != 2'b00)) begin
            m_mis      = 1'b1;
            m_mis_addr = jump_addr_i;
        end else begin
            m_mis = 1'b0;
        end
        if (take) void'(mq.pop_front());
        if (fire) begin
            e.pc    = m_pc;
            e.stale = 1'b0;
            mq.push_back(e);
            m_pc = m_pc + 32'd4;
        end
        if (jump_flag_i) begin
            m_pc = {jump_addr_i[31:2], 2'b00};
            foreach (mq[i]) mq[i].stale = 1'b1;
        end
        m_boot = 1'b0;
        @(posedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc       = RESET_PC;
        m_boot     = 1'b1;
        m_mis      = 1'b0;
        m_mis_addr = '0;
    endtask

    task automatic do_reset();
        #2;
        rst_n       = 1'b0;
        jump_flag_i = 1'b0;
        hold_i      = 1'b0;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Return every outstanding fetch with no new requests accepted
    task automatic settle();
        for (int i = 0; i < 8; i++) begin
            if (mq.size() == 0) break;
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, $urandom);
            advance();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hdead_beef);
        checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", req_valid_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b exp 0", inst_valid_o); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b exp 0", misalign_o); end
        checks++; if (misalign_addr_o !== 32'h0) begin errors++; $display("FAIL rst_misalign_addr got %h exp 0", misalign_addr_o); end
        checks++; if (req_addr_o !== RESET_PC) begin errors++; $display("FAIL rst_req_addr got %h exp %h", req_addr_o, RESET_PC); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL boot_req_valid got %b exp 0", req_valid_o); end
        advance();
    endtask

    task automatic test_sequential();
        logic [31:0] nreq;
        logic [31:0] nrsp;
        logic [31:0] data;
        int          outstanding;
        bit          rv;
        nreq = RESET_PC;
        nrsp = RESET_PC;
        outstanding = 0;
        for (int c = 0; c < 12; c++) begin
            data = $urandom;
            rv   = (outstanding > 0);
            drive(1'b0, 32'h0, 1'b0, 1'b1, rv, data);
            checks++; if (req_valid_o !== 1'b1) begin errors++; $display("FAIL seq_req_valid cyc %0d got %b exp 1", c, req_valid_o); end
            checks++; if (req_addr_o !== nreq) begin errors++; $display("FAIL seq_req_addr cyc %0d got %h exp %h", c, req_addr_o, nreq); end
            if (rv) begin
                checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL seq_inst_valid cyc %0d got %b exp 1", c, inst_valid_o); end
                checks++; if (inst_addr_o !== nrsp) begin errors++; $display("FAIL seq_inst_addr cyc %0d got %h exp %h", c, inst_addr_o, nrsp); end
                checks++; if (inst_o !== data) begin errors++; $display("FAIL seq_inst_data cyc %0d got %h exp %h", c, inst_o, data); end
                nrsp = nrsp + 32'd4;
                outstanding--;
            end
            if (req_valid_o) begin
                nreq = nreq + 32'd4;
                outstanding++;
            end
            checks++; if (outstanding > MAX_OS) begin errors++; $display("FAIL seq_outstanding cyc %0d got %0d max %0d", c, outstanding, MAX_OS); end
            advance();
        end
    endtask

    task automatic test_stall();
        logic [31:0] saved;
        settle();
        saved = m_pc;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
            checks++; if (req_valid_o !== 1'b1) begin errors++; $display("FAIL stall_req_valid cyc %0d got %b exp 1", c, req_valid_o); end
            checks++; if (req_addr_o !== saved) begin errors++; $display("FAIL stall_req_addr cyc %0d got %h exp %h", c, req_addr_o, saved); end
            advance();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (req_addr_o !== saved) begin errors++; $display("FAIL stall_resume_addr got %h exp %h", req_addr_o, saved); end
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (req_addr_o !== saved + 32'd4) begin errors++; $display("FAIL stall_next_addr got %h exp %h", req_addr_o, saved + 32'd4); end
        advance();
    endtask

    task automatic test_redirect_drain();
        settle();
        repeat (2) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
            advance();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL drain_full_req_valid got %b exp 0", req_valid_o); end
        advance();
        drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL drain_jump_req_valid got %b exp 0", req_valid_o); end
        advance();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $urandom);
            checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL drain_inst_valid rsp %0d got %b exp 0", c, inst_valid_o); end
            checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL drain_req_valid rsp %0d got %b exp 0", c, req_valid_o); end
            advance();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (req_valid_o !== 1'b1) begin errors++; $display("FAIL drain_target_valid got %b exp 1", req_valid_o); end
        checks++; if (req_addr_o !== 32'h100) begin errors++; $display("FAIL drain_target_addr got %h exp 00000100", req_addr_o); end
        advance();
    endtask

    task automatic test_redirect_same_cycle();
        settle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        advance();
        drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, $urandom);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL same_inst_valid got %b exp 0", inst_valid_o); end
        checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL same_req_valid got %b exp 0", req_valid_o); end
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (req_valid_o !== 1'b1) begin errors++; $display("FAIL same_target_valid got %b exp 1", req_valid_o); end
        checks++; if (req_addr_o !== 32'h200) begin errors++; $display("FAIL same_target_addr got %h exp 00000200", req_addr_o); end
        advance();
    endtask

    task automatic test_hold_redirect();
        settle();
        drive(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL hold_jump_req_valid got %b exp 0", req_valid_o); end
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
            checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL hold_req_valid cyc %0d got %b exp 0", c, req_valid_o); end
            checks++; if (req_addr_o !== 32'h40) begin errors++; $display("FAIL hold_req_addr cyc %0d got %h exp 00000040", c, req_addr_o); end
            advance();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (req_valid_o !== 1'b1) begin errors++; $display("FAIL hold_release_valid got %b exp 1", req_valid_o); end
        checks++; if (req_addr_o !== 32'h40) begin errors++; $display("FAIL hold_release_addr got %h exp 00000040", req_addr_o); end
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (req_addr_o !== 32'h44) begin errors++; $display("FAIL hold_second_addr got %h exp 00000044", req_addr_o); end
        advance();
        drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h0);
        advance();
        drive(1'b1, 32'h80, 1'b0, 1'b1, 1'b1, $urandom);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL redrain_inst_valid0 got %b exp 0", inst_valid_o); end
        checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL redrain_req_valid0 got %b exp 0", req_valid_o); end
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $urandom);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL redrain_inst_valid1 got %b exp 0", inst_valid_o); end
        checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL redrain_req_valid1 got %b exp 0", req_valid_o); end
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (req_valid_o !== 1'b1) begin errors++; $display("FAIL redrain_target_valid got %b exp 1", req_valid_o); end
        checks++; if (req_addr_o !== 32'h80) begin errors++; $display("FAIL redrain_target_addr got %h exp 00000080", req_addr_o); end
        advance();
    endtask

    task automatic test_misalign();
        logic [31:0] exp_addr;
        settle();
        drive(1'b1, 32'h102, 1'b0, 1'b0, 1'b0, 32'h0);
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef IFU_ALIGN_CHK_EN
        exp_addr = 32'h102;
        checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", misalign_o); end
`else
        exp_addr = 32'h0;
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_pulse got %b exp 0", misalign_o); end
`endif
        checks++; if (misalign_addr_o !== exp_addr) begin errors++; $display("FAIL mis_addr got %h exp %h", misalign_addr_o, exp_addr); end
        checks++; if (req_valid_o !== 1'b1) begin errors++; $display("FAIL mis_req_valid got %b exp 1", req_valid_o); end
        checks++; if (req_addr_o !== 32'h100) begin errors++; $display("FAIL mis_req_addr got %h exp 00000100", req_addr_o); end
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %b exp 0", misalign_o); end
        checks++; if (misalign_addr_o !== exp_addr) begin errors++; $display("FAIL mis_addr_hold got %h exp %h", misalign_addr_o, exp_addr); end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] ja;
        logic [31:0] rd;
        bit          jf, hd, rdy, rv;
        bit          e_rv, e_iv, e_mis;
        logic [31:0] e_mis_addr;
        for (int c = 0; c < 1500; c++) begin
            if (c == 750) do_reset();
            jf  = ($urandom_range(0, 99) < 8);
            ja  = $urandom;
            if ($urandom_range(0, 1) == 0) ja[1:0] = 2'b00;
            hd  = ($urandom_range(0, 99) < 20);
            rdy = ($urandom_range(0, 99) < 70);
            rv  = (mq.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
            rd  = $urandom;
            drive(jf, ja, hd, rdy, rv, rd);
            e_rv = exp_req_valid();
            e_iv = exp_inst_valid();
`ifdef IFU_ALIGN_CHK_EN
            e_mis      = m_mis;
            e_mis_addr = m_mis_addr;
`else
            e_mis      = 1'b0;
            e_mis_addr = 32'h0;
`endif
            checks++; if (req_valid_o !== e_rv) begin errors++; $display("FAIL rnd_req_valid cyc %0d got %b exp %b", c, req_valid_o, e_rv); end
            checks++; if (req_addr_o !== m_pc) begin errors++; $display("FAIL rnd_req_addr cyc %0d got %h exp %h", c, req_addr_o, m_pc); end
            checks++; if (inst_valid_o !== e_iv) begin errors++; $display("FAIL rnd_inst_valid cyc %0d got %b exp %b", c, inst_valid_o, e_iv); end
            if (e_iv) begin
                checks++; if (inst_addr_o !== mq[0].pc) begin errors++; $display("FAIL rnd_inst_addr cyc %0d got %h exp %h", c, inst_addr_o, mq[0].pc); end
                checks++; if (inst_o !== rd) begin errors++; $display("FAIL rnd_inst_data cyc %0d got %h exp %h", c, inst_o, rd); end
            end
            checks++; if (misalign_o !== e_mis) begin errors++; $display("FAIL rnd_misalign cyc %0d got %b exp %b", c, misalign_o, e_mis); end
            checks++; if (misalign_addr_o !== e_mis_addr) begin errors++; $display("FAIL rnd_misalign_addr cyc %0d got %h exp %h", c, misalign_addr_o, e_mis_addr); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drain();
        test_redirect_same_cycle();
        test_hold_redirect();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
